// File: rtl/luna_wb_pkg.sv
//------------------------------------------------------------------------------
// Module   : luna_wb_pkg
// Purpose  : Shared types and instruction field positions for the writeback
//            stage and its helpers.
// Contents : wb_state_t FSM encoding, instruction field bit indices,
//            A-instruction immediate width.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package luna_wb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    SETTLE = 2'd2
  } wb_state_t;

  // Instruction word layout
  localparam int INSTR_TYPE_BIT = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int DEST_A         = 5;
  localparam int DEST_D         = 4;
  localparam int DEST_M         = 3;
  localparam int JMP_LT         = 2;
  localparam int JMP_EQ         = 1;
  localparam int JMP_GT         = 0;

  // Width of the immediate carried by an A-instruction
  localparam int A_IMM_W        = 15;

endpackage

`default_nettype wire

// File: rtl/wb_jump_cond.sv
//------------------------------------------------------------------------------
// Module   : wb_jump_cond
// Purpose  : Combinational jump-condition evaluation. Kept separate so a
//            future branch predictor can reuse the exact same decision.
// Ports    : i_jmp[2:0]   jump bits {LT,EQ,GT}
//            i_zr         ALU result is zero
//            i_ng         ALU result is negative
//            i_is_c       instruction is a C-instruction
//            o_jump_taken jump condition satisfied
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_jump_cond
  import luna_wb_pkg::*;
(
  input  logic [2:0] i_jmp,
  input  logic       i_zr,
  input  logic       i_ng,
  input  logic       i_is_c,
  output logic       o_jump_taken
);

  // Positive means neither negative nor zero.
  assign o_jump_taken = i_is_c & ((i_jmp[JMP_LT] & i_ng) |
                                  (i_jmp[JMP_EQ] & i_zr) |
                                  (i_jmp[JMP_GT] & ~i_ng & ~i_zr));

endmodule

`default_nettype wire

// File: rtl/writeback_sequencer.sv
//------------------------------------------------------------------------------
// Module   : writeback_sequencer
// Purpose  : Writeback stage feeding the A/D/M register and BRAM controller.
//            Accepts one executed instruction per handshake, pulses the
//            register/memory write enables for one cycle, owns the program
//            counter (including jump resolution) and stalls after M writes
//            so the BRAM write commits before the next M read.
// Params   : PC_RESET       program counter value after reset
//            SETTLE_CYCLES  stall cycles after an M write (0 allowed)
// Ports    : wrbk_clk, rst (sync, active-high)
//            instr_valid/instr_ready  upstream handshake
//            instr, alu_out, alu_zr, alu_ng, reg_a_cur  executed instruction
//            reg_a_en, reg_d_en, reg_m_en, data_in      controller write side
//            program_counter                            current PC
//            halted (only with WRBK_HALT_DETECT_EN)     jump-to-self seen
// Options  : WRBK_HALT_DETECT_EN - adds halt-on-jump-to-self detection
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_sequencer
  import luna_wb_pkg::*;
#(
  parameter logic [15:0] PC_RESET      = 16'h0000,
  parameter int          SETTLE_CYCLES = 1
)
(
  input  logic        wrbk_clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic [15:0] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [15:0] reg_a_cur,
  output logic        reg_a_en,
  output logic        reg_d_en,
  output logic        reg_m_en,
  output logic [15:0] data_in,
  output logic [15:0] program_counter
`ifdef WRBK_HALT_DETECT_EN
  ,
  output logic        halted
`endif
);

  localparam int CNT_W       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
  localparam bit HAS_SETTLE  = (SETTLE_CYCLES > 0);
  localparam logic [CNT_W-1:0] c_SETTLE_LAST = CNT_W'(SETTLE_LAST);

  wb_state_t         r_state;
  wb_state_t         w_next_state;

  logic              r_is_c;
  logic [2:0]        r_jmp;
  logic              r_zr;
  logic              r_ng;
  logic [15:0]       r_a_cur;
  logic              r_a_en;
  logic              r_d_en;
  logic              r_m_en;
  logic [15:0]       r_data;
  logic [15:0]       r_pc;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_ready;
  logic              w_accept;
  logic              w_jump_taken;
  logic              w_halt_block;

  // Jump decision always uses the flags and jump bits captured at acceptance.
  wb_jump_cond u_jump_cond (
    .i_jmp        (r_jmp),
    .i_zr         (r_zr),
    .i_ng         (r_ng),
    .i_is_c       (r_is_c),
    .o_jump_taken (w_jump_taken)
  );

  assign w_ready  = (r_state == IDLE) & ~rst & ~w_halt_block;
  assign w_accept = instr_valid & w_ready;

  // State register
  always_ff @(posedge wrbk_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = COMMIT;
      COMMIT:  w_next_state = (r_m_en && HAS_SETTLE) ? SETTLE : IDLE;
      SETTLE:  if (r_cnt == c_SETTLE_LAST) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: capture, registered decode, PC update, settle counter
  always_ff @(posedge wrbk_clk) begin
    if (rst) begin
      r_is_c  <= 1'b0;
      r_jmp   <= 3'b000;
      r_zr    <= 1'b0;
      r_ng    <= 1'b0;
      r_a_cur <= 16'h0000;
      r_a_en  <= 1'b0;
      r_d_en  <= 1'b0;
      r_m_en  <= 1'b0;
      r_data  <= 16'h0000;
      r_pc    <= PC_RESET;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_is_c  <= instr[INSTR_TYPE_BIT];
            r_jmp   <= instr[JMP_LT:JMP_GT];
            r_zr    <= alu_zr;
            r_ng    <= alu_ng;
            r_a_cur <= reg_a_cur;
            if (instr[INSTR_TYPE_BIT]) begin
              r_a_en <= instr[DEST_A];
              r_d_en <= instr[DEST_D];
              r_m_en <= instr[DEST_M];
              r_data <= alu_out;
            end else begin
              r_a_en <= 1'b1;
              r_d_en <= 1'b0;
              r_m_en <= 1'b0;
              r_data <= {1'b0, instr[A_IMM_W-1:0]};
            end
          end else begin
            r_a_en <= 1'b0;
            r_d_en <= 1'b0;
            r_m_en <= 1'b0;
          end
        end
        COMMIT: begin
          // Controller samples the enables on this edge; data_in is held.
          r_a_en <= 1'b0;
          r_d_en <= 1'b0;
          r_m_en <= 1'b0;
          // Target is the A value seen before this instruction's own A write.
          r_pc   <= w_jump_taken ? r_a_cur : r_pc + 16'd1;
          r_cnt  <= '0;
        end
        SETTLE: begin
          r_cnt  <= r_cnt + CNT_W'(1);
        end
        default: begin
          r_a_en <= 1'b0;
          r_d_en <= 1'b0;
          r_m_en <= 1'b0;
        end
      endcase
    end
  end

`ifdef WRBK_HALT_DETECT_EN
  logic r_halted;

  // A taken jump whose target is its own PC can never make progress.
  always_ff @(posedge wrbk_clk) begin
    if (rst) begin
      r_halted <= 1'b0;
    end else if ((r_state == COMMIT) && w_jump_taken && (r_a_cur == r_pc)) begin
      r_halted <= 1'b1;
    end
  end

  assign halted       = r_halted;
  assign w_halt_block = r_halted;
`else
  assign w_halt_block = 1'b0;
`endif

  assign instr_ready     = w_ready;
  assign reg_a_en        = r_a_en;
  assign reg_d_en        = r_d_en;
  assign reg_m_en        = r_m_en;
  assign data_in         = r_data;
  assign program_counter = r_pc;

endmodule

`default_nettype wire
